// File: rtl/ring_evt_arb.sv
// Event-building arbiter: waits for every enabled ringbuf channel to hold an event,
// then drains the channels one at a time in ascending order into a shared event buffer.
module ring_evt_arb #(
    parameter int N_CH    = 6,
    parameter int WPS     = 16,
    parameter int TMO_CYC = 1023
) (
    input  logic                CLK,
    input  logic                RST_RESYNC,
    input  logic                ENABLE,
    input  logic [6:0]          SAMP_MAX,
    input  logic [N_CH-1:0]     CH_MASK,
    input  logic [N_CH-1:0]     CH_RDY,
    input  logic [18*N_CH-1:0]  CH_DATA,
    input  logic [N_CH-1:0]     CH_PUSH,
    input  logic                EVT_BUF_AFL,
    output logic [N_CH-1:0]     GNT,
    output logic [17:0]         OUT_DATA,
    output logic                OUT_WE,
    output logic [2:0]          OUT_CH,
    output logic                EVT_DONE,
    output logic                BUSY,
    output logic [15:0]         EVT_CNT,
    output logic                ERR_TMO,
    output logic                ERR_PROTO
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_NEXT    = 2'd2;
    localparam logic [1:0] ST_EVT_END = 2'd3;

    localparam int            TW      = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_VAL = TW'(TMO_CYC);

    logic [1:0]      r_state;
    logic [2:0]      r_ptr;
    logic [N_CH-1:0] r_mask;
    logic [11:0]     r_total;
    logic [11:0]     r_cnt;
    logic [TW-1:0]   r_timer;
    logic [17:0]     r_out_data;
    logic            r_out_we;
    logic [2:0]      r_out_ch;
    logic [15:0]     r_evt_cnt;
    logic            r_err_tmo;
    logic            r_err_proto;

    logic [17:0]     w_word [8];
    logic [7:0]      w_push8;
    logic            w_gnt_on;
    logic            w_push_own;
    logic            w_push_other;
    logic            w_start;
    logic [11:0]     w_total_calc;
    logic [11:0]     w_cnt_inc;
    logic            w_last;
    logic            w_tmo;
    logic [2:0]      w_first_ptr;
    logic [2:0]      w_next_ptr;
    logic            w_next_vld;

    // Pad channel words/pushes to 8 entries so a 3-bit pointer can index safely.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < N_CH) begin : g_ch
                assign w_word[gi]  = CH_DATA[18*gi +: 18];
                assign w_push8[gi] = CH_PUSH[gi];
            end else begin : g_zero
                assign w_word[gi]  = '0;
                assign w_push8[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_gnt_on     = (r_state == ST_GRANT) && !EVT_BUF_AFL;
    assign w_push_own   = w_push8[r_ptr];
    assign w_push_other = |(w_push8 & ~(8'd1 << r_ptr));

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_gnt
            assign GNT[gi] = w_gnt_on && (r_ptr == 3'(gi));
        end
    endgenerate

    assign w_start = ENABLE && (CH_MASK != '0) &&
                     ((CH_RDY & CH_MASK) == CH_MASK) && !EVT_BUF_AFL;

    assign w_total_calc = 12'((int'(SAMP_MAX) + 1) * WPS);
    assign w_cnt_inc    = r_cnt + 12'd1;
    assign w_last       = w_push_own && (w_cnt_inc == r_total);
    assign w_tmo        = !w_push_own && (r_timer == TMO_VAL);

    always_comb begin
        w_first_ptr = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (CH_MASK[i]) begin
                w_first_ptr = 3'(i);
            end
        end
    end

    always_comb begin
        w_next_ptr = 3'd0;
        w_next_vld = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_ptr))) begin
                w_next_ptr = 3'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_mask      <= '0;
            r_total     <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_out_data  <= '0;
            r_out_we    <= 1'b0;
            r_out_ch    <= '0;
            r_evt_cnt   <= '0;
            r_err_tmo   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_out_we <= 1'b0;
            if (w_push_other) begin
                r_err_proto <= 1'b1;
            end
            // Late pushes arriving while GNT is held low still count and are forwarded.
            if ((r_state == ST_GRANT) && w_push_own) begin
                r_out_data <= w_word[r_ptr];
                r_out_we   <= 1'b1;
                r_out_ch   <= r_ptr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_GRANT;
                        r_ptr   <= w_first_ptr;
                        r_mask  <= CH_MASK;
                        r_total <= w_total_calc;
                        r_cnt   <= '0;
                        r_timer <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_push_own) begin
                        r_cnt   <= w_cnt_inc;
                        r_timer <= '0;
                        if (w_last) begin
                            r_state <= ST_NEXT;
                        end
                    end else if (w_tmo) begin
                        r_err_tmo <= 1'b1;
                        r_state   <= ST_NEXT;
                    end else if (w_gnt_on) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (w_next_vld) begin
                        r_ptr   <= w_next_ptr;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        r_state <= ST_GRANT;
                    end else begin
                        r_state <= ST_EVT_END;
                    end
                end
                default: begin
                    r_evt_cnt <= r_evt_cnt + 16'd1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign OUT_DATA  = r_out_data;
    assign OUT_WE    = r_out_we;
    assign OUT_CH    = r_out_ch;
    assign EVT_DONE  = (r_state == ST_EVT_END);
    assign BUSY      = (r_state != ST_IDLE);
    assign EVT_CNT   = r_evt_cnt;
    assign ERR_TMO   = r_err_tmo;
    assign ERR_PROTO = r_err_proto;

endmodule
